nav_waypoint_driver: RTL and testbench

Command-side driver for the per-axis position integrators. It accepts 3-D waypoints over a valid/ready handshake. Each cycle it generates the one-hot pos_mode, velocity and jump_position that the position integrators consume. It keeps a shadow copy of the integrated position, so it knows exactly when the ship has arrived.

---
 rtl/nav_pkg.sv | 31 +++
 rtl/nav_waypoint_driver_if.sv | 28 ++
 rtl/nav_axis_step.sv | 36 +++
 rtl/nav_waypoint_driver.sv | 138 +++++++++++++
 tb/tb_nav_waypoint_driver.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/nav_pkg.sv
// Shared definitions for the waypoint driver: pos_mode codes, FSM
// state encoding, default sizing and {Z,Y,X} axis slice helpers.
package nav_pkg;

   localparam int K_DEF        = 16;
   localparam int MAX_STEP_DEF = 4;
   localparam int JUMP_MIN_DEF = 64;

   localparam logic [3:0] POS_RESET  = 4'b0001;
   localparam logic [3:0] POS_NORMAL = 4'b0010;
   localparam logic [3:0] POS_JUMP   = 4'b0100;

   typedef enum logic [2:0] {
      ST_INIT,
      ST_IDLE,
      ST_MOVE,
      ST_JUMP,
      ST_DONE
   } nav_state_e;

   localparam int AXIS_X = 0;
   localparam int AXIS_Y = 1;
   localparam int AXIS_Z = 2;
   localparam int N_AXES = 3;

   // LSB of an axis inside a packed {Z,Y,X} vector of k-bit fields.
   function automatic int axis_lsb(input int axis, input int k);
      return axis * k;
   endfunction

endpackage

// File: rtl/nav_waypoint_driver_if.sv
// Waypoint handshake and integrator command bundle.
// The driver sits on the slave side; the waypoint source / integrators
// (or a bench) use the master side.
interface nav_waypoint_driver_if #(parameter int K = 16);

   logic           wp_valid;
   logic           wp_ready;
   logic [3*K-1:0] wp_target;
   logic           wp_jump_ok;
   logic           hold;
   logic [3:0]     pos_mode;
   logic [3*K-1:0] jump_position;
   logic [3*K-1:0] velocity;
   logic [3*K-1:0] cur_pos;
   logic           busy;
   logic           arrived;

   modport master (
      output wp_valid, wp_target, wp_jump_ok, hold,
      input  wp_ready, pos_mode, jump_position, velocity, cur_pos, busy, arrived
   );

   modport slave (
      input  wp_valid, wp_target, wp_jump_ok, hold,
      output wp_ready, pos_mode, jump_position, velocity, cur_pos, busy, arrived
   );

endinterface

// File: rtl/nav_axis_step.sv
// One axis of the motion step: signed distance to target, velocity
// clamped to +/-MAX_STEP (zero while held), and whether this step lands
// exactly on the target.
module nav_axis_step #(
   parameter int K        = 16,
   parameter int MAX_STEP = 4
) (
   input  logic [K-1:0]        target_i,
   input  logic [K-1:0]        cur_pos_i,
   input  logic                hold_i,
   output logic signed [K-1:0] diff_o,
   output logic [K-1:0]        vel_o,
   output logic                at_target_o
);

   localparam logic signed [K-1:0] STEP_P = K'(MAX_STEP);
   localparam logic signed [K-1:0] STEP_N = -STEP_P;

   logic signed [K-1:0] clamp;

   // Wrapped difference, clamp (most-negative diff falls into the
   // STEP_N branch), and exact-landing flag.
   always_comb begin
      diff_o = $signed(target_i - cur_pos_i);
      if (diff_o > STEP_P) begin
         clamp = STEP_P;
      end else if (diff_o < STEP_N) begin
         clamp = STEP_N;
      end else begin
         clamp = diff_o;
      end
      vel_o       = hold_i ? '0 : clamp;
      at_target_o = ((cur_pos_i + vel_o) == target_i);
   end

endmodule

// File: rtl/nav_waypoint_driver.sv
// Waypoint driver for the per-axis position integrators.
// Optional jump support is compiled in with the macro NAV_JUMP_EN;
// without it every non-zero waypoint is walked in MOVE.
//
// state | meaning
// INIT  | one cycle after reset, pos_mode=reset
// IDLE  | ready for a waypoint
// MOVE  | stepping toward target, clamped velocity
// JUMP  | one cycle, integrators load jump_position
// DONE  | one cycle, arrived pulse
module nav_waypoint_driver
   import nav_pkg::*;
#(
   parameter int K        = K_DEF,
   parameter int MAX_STEP = MAX_STEP_DEF,
   parameter int JUMP_MIN = JUMP_MIN_DEF
) (
   input logic                  clk,
   input logic                  rst,
   nav_waypoint_driver_if.slave bus
);

   localparam logic [K:0] JUMP_MIN_W = (K+1)'(JUMP_MIN);

   nav_state_e     state_q, state_d;
   logic [3*K-1:0] cur_pos_q, cur_pos_d;
   logic [3*K-1:0] target_q, target_d;
   logic           hold_q;

   logic [3*K-1:0] diff, vel_step, step_pos, acc_diff;
   logic [N_AXES-1:0] at_tgt;
   logic [K:0]     acc_abs [N_AXES];
   logic           acc_zero, acc_far, jump_take;
   logic           unused_diff;

   function automatic logic [K:0] abs_k(input logic [K-1:0] d);
      return d[K-1] ? ({1'b0, ~d} + (K+1)'(1)) : {1'b0, d};
   endfunction

   for (genvar a = 0; a < N_AXES; a++) begin : g_axis
      nav_axis_step #(.K(K), .MAX_STEP(MAX_STEP)) u_step (
         .target_i    (target_q[a*K +: K]),
         .cur_pos_i   (cur_pos_q[a*K +: K]),
         .hold_i      (hold_q),
         .diff_o      (diff[a*K +: K]),
         .vel_o       (vel_step[a*K +: K]),
         .at_target_o (at_tgt[a])
      );
      assign step_pos[a*K +: K] = cur_pos_q[a*K +: K] + vel_step[a*K +: K];
      assign acc_diff[a*K +: K] = bus.wp_target[a*K +: K] - cur_pos_q[a*K +: K];
      assign acc_abs[a]         = abs_k(acc_diff[a*K +: K]);
   end

   // The signed diffs are only needed inside the step units.
   assign unused_diff = ^diff;

   assign acc_zero    = (acc_diff == '0);
   assign bus.cur_pos = cur_pos_q;

   // Chebyshev distance of the offered waypoint against the jump threshold.
   always_comb begin
      acc_far = 1'b0;
      for (int a = 0; a < N_AXES; a++) begin
         if (acc_abs[a] >= JUMP_MIN_W) acc_far = 1'b1;
      end
   end

`ifdef NAV_JUMP_EN
   assign jump_take = bus.wp_jump_ok & acc_far;
`else
   logic unused_jump;
   assign unused_jump = bus.wp_jump_ok ^ acc_far;
   assign jump_take   = 1'b0;
`endif

   // Next-state, shadow position update and output decode from state.
   always_comb begin
      state_d           = state_q;
      cur_pos_d         = cur_pos_q;
      target_d          = target_q;
      bus.pos_mode      = POS_NORMAL;
      bus.velocity      = '0;
      bus.jump_position = '0;
      bus.wp_ready      = 1'b0;
      bus.busy          = 1'b1;
      bus.arrived       = 1'b0;
      case (state_q)
         ST_INIT: begin
            bus.pos_mode = POS_RESET;
            state_d      = ST_IDLE;
         end
         ST_IDLE: begin
            bus.wp_ready = 1'b1;
            bus.busy     = 1'b0;
            if (bus.wp_valid) begin
               target_d = bus.wp_target;
               if (acc_zero)       state_d = ST_DONE;
               else if (jump_take) state_d = ST_JUMP;
               else                state_d = ST_MOVE;
            end
         end
         ST_MOVE: begin
            bus.velocity = vel_step;
            cur_pos_d    = step_pos;
            if (&at_tgt) state_d = ST_DONE;
         end
`ifdef NAV_JUMP_EN
         ST_JUMP: begin
            bus.pos_mode      = POS_JUMP;
            bus.jump_position = target_q;
            cur_pos_d         = target_q;
            state_d           = ST_DONE;
         end
`endif
         ST_DONE: begin
            bus.arrived = 1'b1;
            state_d     = ST_IDLE;
         end
         default: state_d = ST_INIT;
      endcase
   end

   // State, shadow position, latched target and registered hold.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_INIT;
         cur_pos_q <= '0;
         target_q  <= '0;
         hold_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cur_pos_q <= cur_pos_d;
         target_q  <= target_d;
         hold_q    <= bus.hold;
      end
   end

endmodule

// File: tb/tb_nav_waypoint_driver.sv
// Directed bench for nav_waypoint_driver (K=16, MAX_STEP=4, JUMP_MIN=64).
// A waypoint table drives the common paths; hand sequences cover reset,
// hold, busy pokes and reset during a move.
module tb_nav_waypoint_driver;
   import nav_pkg::*;

`ifdef NAV_JUMP_EN
   localparam bit JMP = 1'b1;
`else
   localparam bit JMP = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst;

   nav_waypoint_driver_if #(.K(16)) bus ();

   nav_waypoint_driver #(.K(16), .MAX_STEP(4), .JUMP_MIN(64)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          do_rst;
      logic [47:0] tgt;
      logic        jo;
      int          moves;
      int          jumps;
      logic [47:0] v0;
      logic [47:0] pos;
   } vec_t;

   vec_t        vt [10];
   logic [47:0] vel_log [64];
   int          nvec = 0;
   int          errs = 0;

   task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
      nvec++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   // Offer one waypoint and follow it to arrived. Starts and ends on a negedge.
   task automatic run_wp(input string nm, input logic [47:0] tgt, input logic jo,
                         input int hold_at, input int hold_len, input int poke_at,
                         output int moves, output int jumps,
                         output logic [47:0] jpos, output logic [47:0] pos_done,
                         output logic bad);
      bit done;
      int n;
      moves = 0; jumps = 0; jpos = '0; pos_done = '0; bad = 1'b0; done = 0;
      n = 0;
      while (!bus.wp_ready && n < 10) begin
         @(negedge clk);
         n++;
      end
      if (!bus.wp_ready) begin
         nvec++; errs++;
         $display("FAIL %s.ready_timeout: wp_ready stayed 0", nm);
      end
      bus.wp_valid   = 1'b1;
      bus.wp_target  = tgt;
      bus.wp_jump_ok = jo;
      @(posedge clk);
      @(negedge clk);
      bus.wp_valid = 1'b0;
      for (n = 1; n <= 9000; n++) begin
         if (bus.arrived) begin
            pos_done = bus.cur_pos;
            done = 1;
            break;
         end
         if (bus.pos_mode == POS_JUMP) begin
            jumps++;
            jpos = bus.jump_position;
            if (bus.velocity != '0) bad = 1'b1;
         end else begin
            if (moves < 64) vel_log[moves] = bus.velocity;
            moves++;
            if (bus.pos_mode != POS_NORMAL || bus.jump_position != '0 ||
                bus.wp_ready || !bus.busy) bad = 1'b1;
         end
         if (n == poke_at) begin
            chk({nm, ".poke_ready"}, 48'(bus.wp_ready), 48'd0);
            bus.wp_valid  = 1'b1;
            bus.wp_target = 48'h0000_0000_1234;
         end else if (n == poke_at + 1) begin
            bus.wp_valid = 1'b0;
         end
         if (n == hold_at) bus.hold = 1'b1;
         if (n == hold_at + hold_len) bus.hold = 1'b0;
         @(negedge clk);
      end
      bus.wp_valid = 1'b0;
      bus.hold     = 1'b0;
      if (!done) begin
         nvec++; errs++;
         $display("FAIL %s.arrive_timeout: no arrived after %0d cycles", nm, n);
      end
      @(negedge clk);
      chk({nm, ".post_idle"}, {46'd0, bus.arrived, bus.wp_ready}, 48'd1);
   endtask

   int          mv, jp;
   logic [47:0] jpos, pdone;
   logic        bad;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst            = 1'b1;
      bus.wp_valid   = 1'b0;
      bus.wp_target  = '0;
      bus.wp_jump_ok = 1'b0;
      bus.hold       = 1'b0;

      vt[0] = '{1'b1, 48'h0000_FFFD_000A, 1'b0, 3, 0, 48'h0000_FFFD_0004, 48'h0000_FFFD_000A};
      vt[1] = '{1'b1, 48'h0000_0000_0064, 1'b1, JMP ? 0 : 25, JMP ? 1 : 0,
                48'h0000_0000_0004, 48'h0000_0000_0064};
      vt[2] = '{1'b1, 48'h0000_0000_0064, 1'b0, 25, 0, 48'h0000_0000_0004, 48'h0000_0000_0064};
      vt[3] = '{1'b0, 48'h0000_0000_0064, 1'b1, 0, 0, 48'h0, 48'h0000_0000_0064};
      vt[4] = '{1'b0, 48'h0000_0000_FFFE, 1'b0, 26, 0, 48'h0000_0000_FFFC, 48'h0000_0000_FFFE};
      vt[5] = '{1'b0, 48'h0000_0000_0002, 1'b0, 1, 0, 48'h0000_0000_0004, 48'h0000_0000_0002};
      vt[6] = '{1'b0, 48'h0000_0000_0002, 1'b0, 0, 0, 48'h0, 48'h0000_0000_0002};
      vt[7] = '{1'b1, 48'h0000_0000_8000, 1'b0, 8192, 0, 48'h0000_0000_FFFC, 48'h0000_0000_8000};
      vt[8] = '{1'b1, 48'h0040_FFC0_0005, 1'b1, JMP ? 0 : 16, JMP ? 1 : 0,
                48'h0004_FFFC_0004, 48'h0040_FFC0_0005};
      vt[9] = '{1'b1, 48'h003F_0000_0000, 1'b1, 16, 0, 48'h0004_0000_0000, 48'h003F_0000_0000};

      // Reset: INIT for one cycle after release, then IDLE.
      do_reset();
      chk("rst.init_mode", 48'(bus.pos_mode), 48'(4'b0001));
      chk("rst.init_ready_busy", {46'd0, bus.wp_ready, bus.busy}, 48'd1);
      @(negedge clk);
      chk("rst.idle_mode", 48'(bus.pos_mode), 48'(4'b0010));
      chk("rst.idle_vel", bus.velocity, 48'd0);
      chk("rst.idle_ready_busy", {46'd0, bus.wp_ready, bus.busy}, 48'd2);
      chk("rst.idle_pos", bus.cur_pos, 48'd0);

      for (int i = 0; i < 10; i++) begin
         if (vt[i].do_rst) do_reset();
         run_wp($sformatf("v%0d", i), vt[i].tgt, vt[i].jo, 0, 0, 0, mv, jp, jpos, pdone, bad);
         chk($sformatf("v%0d.moves", i), 48'(mv), 48'(vt[i].moves));
         chk($sformatf("v%0d.jumps", i), 48'(jp), 48'(vt[i].jumps));
         chk($sformatf("v%0d.pos", i), pdone, vt[i].pos);
         chk($sformatf("v%0d.mode_bad", i), 48'(bad), 48'd0);
         if (vt[i].moves > 0) chk($sformatf("v%0d.vel0", i), vel_log[0], vt[i].v0);
         if (vt[i].jumps > 0) chk($sformatf("v%0d.jpos", i), jpos, vt[i].tgt);
      end

      // Velocity profile of the basic move: X 4,4,2 and Y -3,0,0.
      do_reset();
      run_wp("prof", 48'h0000_FFFD_000A, 1'b0, 0, 0, 0, mv, jp, jpos, pdone, bad);
      chk("prof.vel1", vel_log[0], 48'h0000_FFFD_0004);
      chk("prof.vel2", vel_log[1], 48'h0000_0000_0004);
      chk("prof.vel3", vel_log[2], 48'h0000_0000_0002);

      // Hold for 3 cycles from MOVE cycle 2, plus a waypoint poke while busy.
      do_reset();
      run_wp("hold", 48'h0000_0000_0028, 1'b0, 2, 3, 7, mv, jp, jpos, pdone, bad);
      chk("hold.moves", 48'(mv), 48'd13);
      chk("hold.vel_c2", vel_log[1], 48'h0000_0000_0004);
      chk("hold.vel_c3", vel_log[2], 48'd0);
      chk("hold.vel_c5", vel_log[4], 48'd0);
      chk("hold.vel_c6", vel_log[5], 48'h0000_0000_0004);
      chk("hold.pos", pdone, 48'h0000_0000_0028);

      // Reset during the second MOVE cycle.
      do_reset();
      @(negedge clk);
      bus.wp_valid   = 1'b1;
      bus.wp_target  = 48'h0000_0000_0064;
      bus.wp_jump_ok = 1'b0;
      @(posedge clk);
      @(negedge clk);
      bus.wp_valid = 1'b0;
      @(negedge clk);
      chk("rmid.vel_c2", bus.velocity, 48'h0000_0000_0004);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      chk("rmid.mode", 48'(bus.pos_mode), 48'(4'b0001));
      chk("rmid.pos", bus.cur_pos, 48'd0);
      chk("rmid.arrived_init", 48'(bus.arrived), 48'd0);
      @(negedge clk);
      chk("rmid.idle", {44'd0, bus.pos_mode}, 48'(4'b0010));
      chk("rmid.idle_ready_arr", {46'd0, bus.wp_ready, bus.arrived}, 48'd2);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, errs);
      $finish;
   end

endmodule
